// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
//
// Shares one sequential shift-add multiplier among NUM_REQ requesters.
// One operand pair is accepted at a time, using round-robin priority.
// The multiplier is then sequenced through start, wait-for-done and product
// capture. The product is returned on a single backpressured response
// channel, tagged with the index of the requester that owns it.
//
// Parameters
//   WIDTH    operand width; the product is 2*WIDTH bits.
//   NUM_REQ  number of requesters, 2..8.
//   TIMEOUT  WAIT-state cycle limit. It is only used when
//            MULT_ARB_TIMEOUT_EN is defined.
//
// Optional feature (macro MULT_ARB_TIMEOUT_EN)
//   When defined, a 10-bit counter runs while waiting for mul_done. After
//   TIMEOUT cycles without done, an error response is returned
//   (rsp_err = 1, rsp_product = 0). When undefined, the controller waits for
//   done indefinitely and rsp_err is tied low.
//
// Ports
//   clk, rst             clock (rising edge); asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake; ready is one-hot or zero
//   req_a, req_b         packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready  response handshake
//   rsp_id               index of the requester owning the response
//   rsp_product, rsp_err response payload
//   mul_start, mul_valid_in, mul_a, mul_b   multiplier command
//   mul_product, mul_done                   multiplier result
//   busy                 high whenever the controller is not idle
// ---------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]         rsp_product,
    output logic                       rsp_err,
    output logic                       mul_start,
    output logic                       mul_valid_in,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_product,
    input  logic                       mul_done,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 1023) begin : g_param_check
        $error("mult_share_arbiter: NUM_REQ must be 2..8 and TIMEOUT 1..1023");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        RESP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic [ID_W-1:0]     lat_id;
    logic [WIDTH-1:0]    lat_a;
    logic [WIDTH-1:0]    lat_b;
    logic [2*WIDTH-1:0]  product_q;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
    logic [9:0] timer;
    logic       err_q;
`endif

    // Round-robin pick: the first valid requester after last_grant, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = last_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // Ready is only offered while idle. The grant is always a valid
    // requester, so an offered ready is always a completed handshake.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mul_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A done arriving on the expiry cycle still yields a normal capture.
                if (mul_done) begin
                    state_next = CAPTURE;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (timer == TO_LAST) begin
                    state_next = RESP;
                end
`endif
            end
            CAPTURE: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            lat_id     <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            product_q  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            timer      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        lat_a      <= req_a[int'(grant_id)*WIDTH +: WIDTH];
                        lat_b      <= req_b[int'(grant_id)*WIDTH +: WIDTH];
                        lat_id     <= grant_id;
                        last_grant <= grant_id;
                    end
                end
`ifdef MULT_ARB_TIMEOUT_EN
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + 10'd1;
                    if (!mul_done && timer == TO_LAST) begin
                        product_q <= '0;
                        err_q     <= 1'b1;
                    end
                end
`endif
                CAPTURE: begin
                    // The multiplier holds its product valid for the cycle after done.
                    product_q <= mul_product;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_q     <= 1'b0;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Operands reach the multiplier only while it owns a transaction.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == ISSUE || state == WAIT || state == CAPTURE) begin
            mul_a = lat_a;
            mul_b = lat_b;
        end
    end

    assign mul_valid_in = mul_start;
    assign rsp_valid    = (state == RESP);
    assign rsp_id       = lat_id;
    assign rsp_product  = product_q;
    assign busy         = (state != IDLE);

`ifdef MULT_ARB_TIMEOUT_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

    localparam int WIDTH   = 16;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 1000;
    localparam int ID_W    = 2;
    localparam int PW      = 2 * WIDTH;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [PW-1:0]            rsp_product;
    logic                     rsp_err;
    logic                     mul_start;
    logic                     mul_valid_in;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic [PW-1:0]            mul_product;
    logic                     mul_done;
    logic                     busy;

    int checks = 0;
    int passes = 0;
    int last_grant = NUM_REQ - 1;

    // Multiplier stub state
    int               stub_lat = 1;
    bit               stub_en  = 1'b1;
    int               stub_cnt;
    int               start_cnt = 0;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    mult_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_done(mul_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: stub_lat cycles after the start, pulse done with the product.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done    <= 1'b0;
            mul_product <= '0;
            stub_cnt    <= 0;
            op_a        <= '0;
            op_b        <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_start && mul_valid_in) begin
                stub_cnt <= stub_lat;
                op_a     <= mul_a;
                op_b     <= mul_b;
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1 && stub_en) begin
                    mul_done    <= 1'b1;
                    mul_product <= PW'(op_a) * PW'(op_b);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && mul_start) start_cnt <= start_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rotation: first valid index after the last grant, wrapping.
    function automatic int pick(input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (last_grant + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Entered at a negedge with the requests staged. It serves one transaction
    // and returns at the negedge after the response handshake.
    task automatic serve_one(input int hold, input int lat, output int gid, output logic [PW-1:0] prod);
        int                 exp_id;
        int                 k;
        int                 s0;
        bit                 stable;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [WIDTH-1:0]   ea;
        logic [WIDTH-1:0]   eb;
        logic [PW-1:0]      ep;
        logic [ID_W-1:0]    hid;
        logic [PW-1:0]      hprod;
        stub_lat  = lat;
        rsp_ready = (hold == 0);
        exp_id    = pick(req_valid);
        gid       = -1;
        prod      = '0;
        if (exp_id < 0) begin
            checks++;
            $display("FAIL serve_one: no valid request staged");
            return;
        end
        exp_rdy         = '0;
        exp_rdy[exp_id] = 1'b1;
        ea = req_a[exp_id*WIDTH +: WIDTH];
        eb = req_b[exp_id*WIDTH +: WIDTH];
        ep = PW'(longint'(ea) * longint'(eb));
        #1;
        checks++;
        if (req_ready !== exp_rdy) $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
        else passes++;
        last_grant = exp_id;
        s0 = start_cnt;
        @(negedge clk);
        req_valid[exp_id] = 1'b0;
        k = 1;
        while (!rsp_valid && k < lat + 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== lat + 4) $display("FAIL rsp_latency: got %0d cycles expected %0d", k, lat + 4);
        else passes++;
        checks++;
        if (start_cnt - s0 !== 1) $display("FAIL start_pulses: got %0d expected 1", start_cnt - s0);
        else passes++;
        checks++;
        if (rsp_id !== ID_W'(exp_id)) $display("FAIL rsp_id: got %0d expected %0d", rsp_id, exp_id);
        else passes++;
        checks++;
        if (rsp_product !== ep) $display("FAIL rsp_product: got %0h expected %0h", rsp_product, ep);
        else passes++;
        checks++;
        if (rsp_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL rsp_flags: err=%b busy=%b expected err=0 busy=1", rsp_err, busy);
        else passes++;
        gid   = int'(rsp_id);
        prod  = rsp_product;
        hid   = rsp_id;
        hprod = rsp_product;
        stable = 1'b1;
        s0 = start_cnt;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== hid || rsp_product !== hprod || req_ready !== '0)
                stable = 1'b0;
        end
        if (hold > 0) begin
            checks++;
            if (stable !== 1'b1 || start_cnt !== s0)
                $display("FAIL backpressure_hold: stable=%b extra_starts=%0d expected stable=1 extra=0",
                         stable, start_cnt - s0);
            else passes++;
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0) $display("FAIL ready_during_resp: req_ready=%b expected 0", req_ready);
        else passes++;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || mul_a !== '0 || mul_b !== '0)
            $display("FAIL after_handshake: rsp_valid=%b busy=%b mul_a=%0h mul_b=%0h expected all 0",
                     rsp_valid, busy, mul_a, mul_b);
        else passes++;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b busy=%b expected 0", req_ready, rsp_valid, busy);
        else passes++;
        checks++;
        if (mul_start !== 1'b0 || mul_valid_in !== 1'b0 || mul_a !== '0 || mul_b !== '0)
            $display("FAIL reset_mul: start=%b vin=%b a=%0h b=%0h expected 0", mul_start, mul_valid_in, mul_a, mul_b);
        else passes++;
        checks++;
        if (rsp_id !== '0 || rsp_product !== '0 || rsp_err !== 1'b0)
            $display("FAIL reset_rsp: id=%0d product=%0h err=%b expected 0", rsp_id, rsp_product, rsp_err);
        else passes++;
    endtask

    task automatic test_contention();
        int            gid;
        logic [PW-1:0] prod;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
            req_b[i*WIDTH +: WIDTH] = WIDTH'(10);
        end
        req_valid = '1;
        for (int n = 0; n < NUM_REQ; n++) begin
            serve_one(0, n + 1, gid, prod);
            checks++;
            if (gid !== n || prod !== PW'(10 * (n + 1)))
                $display("FAIL contention_order: id=%0d product=%0d expected id=%0d product=%0d",
                         gid, prod, n, 10 * (n + 1));
            else passes++;
        end
        req_a[0*WIDTH +: WIDTH] = 16'd7;
        req_b[0*WIDTH +: WIDTH] = 16'd3;
        req_a[3*WIDTH +: WIDTH] = 16'd5;
        req_b[3*WIDTH +: WIDTH] = 16'd9;
        req_valid = 4'b1001;
        serve_one(0, 2, gid, prod);
        checks++;
        if (gid !== 0 || prod !== 32'd21) $display("FAIL rotation_wrap: id=%0d product=%0d expected 0/21", gid, prod);
        else passes++;
        serve_one(0, 2, gid, prod);
        checks++;
        if (gid !== 3 || prod !== 32'd45) $display("FAIL rotation_next: id=%0d product=%0d expected 3/45", gid, prod);
        else passes++;
    endtask

    task automatic test_single();
        int            gid;
        logic [PW-1:0] prod;
        req_a[2*WIDTH +: WIDTH] = 16'd123;
        req_b[2*WIDTH +: WIDTH] = 16'd456;
        req_valid = 4'b0100;
        serve_one(0, 3, gid, prod);
        checks++;
        if (gid !== 2 || prod !== 32'd56088) $display("FAIL single: id=%0d product=%0d expected 2/56088", gid, prod);
        else passes++;
    endtask

    task automatic test_edge_operands();
        int            gid;
        logic [PW-1:0] prod;
        req_a[1*WIDTH +: WIDTH] = 16'hFFFF;
        req_b[1*WIDTH +: WIDTH] = 16'hFFFF;
        req_valid = 4'b0010;
        serve_one(0, 1, gid, prod);
        checks++;
        if (prod !== 32'hFFFE0001) $display("FAIL edge_max: product=%0h expected fffe0001", prod);
        else passes++;
        req_a[0*WIDTH +: WIDTH] = 16'd0;
        req_b[0*WIDTH +: WIDTH] = 16'd12345;
        req_valid = 4'b0001;
        serve_one(0, 5, gid, prod);
        checks++;
        if (prod !== 32'd0) $display("FAIL edge_zero: product=%0h expected 0", prod);
        else passes++;
        req_a[3*WIDTH +: WIDTH] = 16'd32768;
        req_b[3*WIDTH +: WIDTH] = 16'd2;
        req_valid = 4'b1000;
        serve_one(0, 2, gid, prod);
        checks++;
        if (prod !== 32'd65536) $display("FAIL edge_carry: product=%0h expected 10000", prod);
        else passes++;
    endtask

    task automatic test_backpressure();
        int            gid;
        logic [PW-1:0] prod;
        req_a[1*WIDTH +: WIDTH] = 16'd11;
        req_b[1*WIDTH +: WIDTH] = 16'd13;
        req_a[2*WIDTH +: WIDTH] = 16'd17;
        req_b[2*WIDTH +: WIDTH] = 16'd19;
        req_valid = 4'b0110;
        serve_one(20, 2, gid, prod);
        checks++;
        if (gid !== 1 || prod !== 32'd143) $display("FAIL backpressure_rsp: id=%0d product=%0d expected 1/143", gid, prod);
        else passes++;
        // The pending request must be offered on the cycle right after the handshake.
        serve_one(0, 1, gid, prod);
        checks++;
        if (gid !== 2 || prod !== 32'd323) $display("FAIL backpressure_next: id=%0d product=%0d expected 2/323", gid, prod);
        else passes++;
    endtask

    task automatic test_random();
        int            gid;
        logic [PW-1:0] prod;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            if (req_valid == '0) begin
                int j;
                j = $urandom_range(0, NUM_REQ - 1);
                req_valid[j] = 1'b1;
                req_a[j*WIDTH +: WIDTH] = WIDTH'($urandom);
                req_b[j*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
            serve_one($urandom_range(0, 3), $urandom_range(1, 6), gid, prod);
        end
        for (int n = 0; n < NUM_REQ && req_valid != '0; n++) begin
            serve_one(0, 1, gid, prod);
        end
    endtask

`ifdef MULT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        stub_en = 1'b0;
        req_a[0*WIDTH +: WIDTH] = 16'd9;
        req_b[0*WIDTH +: WIDTH] = 16'd9;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        last_grant = pick(req_valid);
        @(negedge clk);
        req_valid = '0;
        k = 1;
        while (!rsp_valid && k < TIMEOUT + 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== TIMEOUT + 2) $display("FAIL timeout_latency: got %0d expected %0d", k, TIMEOUT + 2);
        else passes++;
        checks++;
        if (rsp_err !== 1'b1 || rsp_product !== '0 || rsp_id !== 2'd0)
            $display("FAIL timeout_rsp: err=%b product=%0h id=%0d expected 1/0/0", rsp_err, rsp_product, rsp_id);
        else passes++;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL timeout_idle: busy=%b rsp_valid=%b expected 0", busy, rsp_valid);
        else passes++;
        stub_en = 1'b1;
    endtask
`endif

    task automatic test_reset_mid_wait();
        int            gid;
        int            wait_cycles;
        bit            held;
        logic [PW-1:0] prod;
`ifdef MULT_ARB_TIMEOUT_EN
        wait_cycles = 10;
`else
        wait_cycles = TIMEOUT + 20;
`endif
        stub_en = 1'b0;
        rsp_ready = 1'b1;
        req_a[3*WIDTH +: WIDTH] = 16'd77;
        req_b[3*WIDTH +: WIDTH] = 16'd88;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        held = 1'b1;
        for (int c = 0; c < wait_cycles; c++) begin
            @(negedge clk);
            if (busy !== 1'b1 || rsp_valid !== 1'b0) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) $display("FAIL wait_forever: busy dropped or response seen, held=%b expected 1", held);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || mul_start !== 1'b0 || mul_a !== '0 || mul_b !== '0
            || rsp_product !== '0 || rsp_id !== '0 || rsp_err !== 1'b0 || req_ready !== '0)
            $display("FAIL reset_abort: busy=%b rsp_valid=%b start=%b a=%0h b=%0h product=%0h id=%0d err=%b rdy=%b expected 0",
                     busy, rsp_valid, mul_start, mul_a, mul_b, rsp_product, rsp_id, rsp_err, req_ready);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        stub_en = 1'b1;
        last_grant = NUM_REQ - 1;
        held = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) $display("FAIL reset_no_rsp: activity after reset, quiet=%b expected 1", held);
        else passes++;
        req_a[1*WIDTH +: WIDTH] = 16'd300;
        req_b[1*WIDTH +: WIDTH] = 16'd301;
        req_valid = 4'b0010;
        serve_one(0, 2, gid, prod);
        checks++;
        if (gid !== 1 || prod !== 32'd90300) $display("FAIL after_reset_txn: id=%0d product=%0d expected 1/90300", gid, prod);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_edge_operands();
        test_backpressure();
        test_random();
`ifdef MULT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
